// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end: word type, fetch FSM
// states, bubble word and default reset vector.
package mips_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    FETCH     = 1'b0,
    MISS_WAIT = 1'b1
  } fetch_state_t;

  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
  localparam word_t DEFAULT_NOP_WORD = 32'h0000_0000;  // sll $0,$0,0

  // Instruction addresses are always word aligned.
  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch control FSM: tracks FETCH / MISS_WAIT, drives the cache request and
// tells the datapath when a fetched word may be captured.
// Optional miss strobe exported under IFU_PERF_COUNTERS_EN.
import mips_pkg::*;

module fetch_ctrl_fsm (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic         icache_hit,
  input  logic         refill_done,
  output fetch_state_t state,
  output logic         icache_req,
  output logic         fetch_fire
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic         miss_fire
`endif
);

  logic advance;

  // A cycle only makes forward progress when nothing upstream holds or squashes it.
  assign advance    = !stall && !redirect_valid;
  assign icache_req = (state == FETCH) && !stall;
  assign fetch_fire = (state == FETCH) && advance && icache_hit;

`ifdef IFU_PERF_COUNTERS_EN
  assign miss_fire  = (state == FETCH) && advance && !icache_hit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else if (redirect_valid) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (!stall && !icache_hit)
            state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          // The refill pulse is honoured even while stalled so it is not lost.
          if (refill_done)
            state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from the I-cache and feeds the
// IF/ID register. Define IFU_PERF_COUNTERS_EN to add fetch/miss counters.
import mips_pkg::*;

module instruction_fetch_unit #(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter int    PC_STEP  = 4,
  parameter word_t NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_hit,
  input  logic [31:0] icache_data,
  input  logic        refill_done,
  output logic [31:0] next_pc,
  output logic [31:0] instruction,
  output logic        hit
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_count
`endif
);

  localparam word_t STEP = word_t'(PC_STEP);

  fetch_state_t state;
  logic         fetch_fire;
  word_t        pc_p0;
  word_t        pc_inc_p0;
  word_t        next_pc_p1;
  word_t        instr_p1;
  logic         vld_p1;

`ifdef IFU_PERF_COUNTERS_EN
  logic         miss_fire;
`endif

  fetch_ctrl_fsm u_fsm (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .icache_hit     (icache_hit),
    .refill_done    (refill_done),
    .state          (state),
    .icache_req     (icache_req),
    .fetch_fire     (fetch_fire)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .miss_fire      (miss_fire)
`endif
  );

  // Stage p0: program counter and cache address
  assign pc_inc_p0   = pc_p0 + STEP;
  assign icache_addr = pc_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_valid) begin
      pc_p0 <= align_word(redirect_pc);
    end else if (fetch_fire) begin
      pc_p0 <= pc_inc_p0;
    end
  end

  // Stage p1: IF/ID-facing registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_pc_p1 <= '0;
      instr_p1   <= NOP_WORD;
      vld_p1     <= 1'b0;
    end else if (redirect_valid) begin
      // Squash whatever was in flight on the wrong path; next_pc is don't-care on a bubble.
      instr_p1   <= NOP_WORD;
      vld_p1     <= 1'b0;
    end else if (stall) begin
      next_pc_p1 <= next_pc_p1;
      instr_p1   <= instr_p1;
      vld_p1     <= vld_p1;
    end else if (fetch_fire) begin
      next_pc_p1 <= pc_inc_p0;
      instr_p1   <= icache_data;
      vld_p1     <= 1'b1;
    end else begin
      instr_p1   <= NOP_WORD;
      vld_p1     <= 1'b0;
    end
  end

  assign next_pc     = next_pc_p1;
  assign instruction = instr_p1;
  assign hit         = vld_p1;

`ifdef IFU_PERF_COUNTERS_EN
  word_t fetch_cnt_p1;
  word_t miss_cnt_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_p1 <= '0;
      miss_cnt_p1  <= '0;
    end else begin
      if (fetch_fire)
        fetch_cnt_p1 <= fetch_cnt_p1 + 32'd1;
      if (miss_fire)
        miss_cnt_p1  <= miss_cnt_p1 + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_p1;
  assign miss_count  = miss_cnt_p1;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit with a simple
// single-miss-line instruction cache model.
import mips_pkg::*;

module tb_instruction_fetch_unit;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  stall = 1'b0;
  logic  redirect_valid = 1'b0;
  word_t redirect_pc = '0;
  logic  refill_done = 1'b0;
  logic  icache_req;
  word_t icache_addr;
  logic  icache_hit;
  word_t icache_data;
  word_t next_pc;
  word_t instruction;
  logic  hit;

`ifdef IFU_PERF_COUNTERS_EN
  word_t fetch_count;
  word_t miss_count;
  int    exp_fetches = 0;
  int    exp_misses  = 0;
`endif

  word_t mem [256];
  word_t miss_addr = 32'h0000_0010;
  logic  resident  = 1'b0;

  typedef struct {
    word_t npc;
    word_t ins;
    logic  h;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Cache model: every line resident except miss_addr until refilled.
  assign icache_data = mem[icache_addr[9:2]];
  assign icache_hit  = (icache_addr != miss_addr) || resident;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_hit     (icache_hit),
    .icache_data    (icache_data),
    .refill_done    (refill_done),
    .next_pc        (next_pc),
    .instruction    (instruction),
    .hit            (hit)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .fetch_count    (fetch_count),
    .miss_count     (miss_count)
`endif
  );

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input word_t npc, input word_t ins, input logic h);
    exp_t e;
    e.npc = npc;
    e.ins = ins;
    e.h   = h;
    exp_q.push_back(e);
`ifdef IFU_PERF_COUNTERS_EN
    if (h && !stall) exp_fetches++;
`endif
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".next_pc"}, next_pc, e.npc);
    chk({tag, ".instruction"}, instruction, e.ins);
    chk({tag, ".hit"}, {31'b0, hit}, {31'b0, e.h});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | word_t'(i);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.next_pc", next_pc, 32'h0);
    chk("rst.instruction", instruction, 32'h0);
    chk("rst.hit", {31'b0, hit}, 32'h0);
    chk("rst.addr", icache_addr, 32'h0);
    reset = 1'b0;
    chk("first.req", {31'b0, icache_req}, 32'h1);

    // Streaming hits from pc 0
    tick("hit0", 32'h4, mem[0], 1'b1);
    tick("hit1", 32'h8, mem[1], 1'b1);

    // Two-cycle stall at pc 0x8
    stall = 1'b1;
    #1;
    chk("stall.req", {31'b0, icache_req}, 32'h0);
    chk("stall.addr", icache_addr, 32'h8);
    tick("stall0", 32'h8, mem[1], 1'b1);
    tick("stall1", 32'h8, mem[1], 1'b1);
    stall = 1'b0;
    #1;
    chk("resume.addr", icache_addr, 32'h8);
    chk("resume.req", {31'b0, icache_req}, 32'h1);
    tick("hit2", 32'hC, mem[2], 1'b1);
    tick("hit3", 32'h10, mem[3], 1'b1);

    // Miss at 0x10, refill three cycles later
    tick("miss0", 32'h10, 32'h0, 1'b0);
`ifdef IFU_PERF_COUNTERS_EN
    exp_misses++;
`endif
    chk("miss.req", {31'b0, icache_req}, 32'h0);
    chk("miss.addr", icache_addr, 32'h10);
    tick("miss1", 32'h10, 32'h0, 1'b0);
    tick("miss2", 32'h10, 32'h0, 1'b0);
    refill_done = 1'b1;
    resident    = 1'b1;
    tick("refill", 32'h10, 32'h0, 1'b0);
    refill_done = 1'b0;
    chk("rereq.addr", icache_addr, 32'h10);
    chk("rereq.req", {31'b0, icache_req}, 32'h1);
    tick("refetch", 32'h14, mem[4], 1'b1);

    // Redirect to unaligned 0x103 while stalled
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick("redir_stall", 32'h14, 32'h0, 1'b0);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("redir.addr", icache_addr, 32'h100);
    chk("redir.req", {31'b0, icache_req}, 32'h1);
    tick("redir_hit", 32'h104, mem[64], 1'b1);

    // Redirect out of MISS_WAIT, then a stray refill pulse
    miss_addr = 32'h104;
    resident  = 1'b0;
    tick("miss_b", 32'h104, 32'h0, 1'b0);
`ifdef IFU_PERF_COUNTERS_EN
    exp_misses++;
`endif
    chk("miss_b.req", {31'b0, icache_req}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick("redir_miss", 32'h104, 32'h0, 1'b0);
    redirect_valid = 1'b0;
    #1;
    chk("redir_miss.addr", icache_addr, 32'h40);
    chk("redir_miss.req", {31'b0, icache_req}, 32'h1);
    refill_done = 1'b1;
    tick("stray", 32'h44, mem[16], 1'b1);
    refill_done = 1'b0;
    chk("stray.req", {31'b0, icache_req}, 32'h1);
    tick("post_stray", 32'h48, mem[17], 1'b1);

    // Asynchronous reset in the middle of a miss
    miss_addr = 32'h48;
    tick("miss_c", 32'h48, 32'h0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst.next_pc", next_pc, 32'h0);
    chk("arst.instruction", instruction, 32'h0);
    chk("arst.hit", {31'b0, hit}, 32'h0);
    chk("arst.addr", icache_addr, 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
    chk("arst.fetch_count", fetch_count, 32'h0);
    chk("arst.miss_count", miss_count, 32'h0);
    exp_fetches = 0;
    exp_misses  = 0;
`endif
    @(posedge clk);
    #1;
    reset     = 1'b0;
    miss_addr = 32'hFFFF_0000;
    chk("arst2.req", {31'b0, icache_req}, 32'h1);
    tick("post_rst", 32'h4, mem[0], 1'b1);

    // PC wraps modulo 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick("redir_wrap", 32'h4, 32'h0, 1'b0);
    redirect_valid = 1'b0;
    #1;
    chk("wrap.addr0", icache_addr, 32'hFFFF_FFFC);
    tick("wrap_hit", 32'h0, mem[255], 1'b1);
    chk("wrap.addr1", icache_addr, 32'h0);

`ifdef IFU_PERF_COUNTERS_EN
    chk("fetch_count", fetch_count, word_t'(exp_fetches));
    chk("miss_count", miss_count, word_t'(exp_misses));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
